// File: rtl/rr_tagged_combiner_if.sv
// Bundle of the per-channel input streams and the single tagged output stream.
// The combiner takes the slave modport; the producer/consumer side takes master.
interface rr_tagged_combiner_if #(
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned CHANNEL_WIDTH_IN  = 32,
  parameter int unsigned CHANNEL_WIDTH_OUT = 64
);
  logic [CHANNEL_WIDTH_IN*NUM_CHANNELS-1:0] in_data;
  logic [NUM_CHANNELS-1:0]                  in_valid;
  logic [NUM_CHANNELS-1:0]                  in_last;
  logic [NUM_CHANNELS-1:0]                  in_ready;
  logic [CHANNEL_WIDTH_OUT-1:0]             out_data;
  logic                                     out_last;
  logic                                     out_valid;
  logic                                     out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/rr_tagged_combiner.sv
// Merges NUM_CHANNELS valid/ready streams into one registered stream, tagging each
// beat with its source channel; optional packet locking keeps packets contiguous.
module rr_tagged_combiner #(
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned CHANNEL_WIDTH_IN  = 32,
  parameter int unsigned CHANNEL_WIDTH_OUT = 64,
  parameter int unsigned TAG_MSB           = 55,
  parameter int unsigned TAG_LSB           = 48,
  parameter int unsigned ARB_MODE          = 1,
  parameter int unsigned LOCK_PACKETS      = 1
) (
  input logic                 clk,
  input logic                 reset,
  rr_tagged_combiner_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned TAG_W = TAG_MSB - TAG_LSB + 1;

  if (NUM_CHANNELS < 1) begin : g_bad_num
    $error("rr_tagged_combiner: NUM_CHANNELS must be >= 1");
  end
  if ((TAG_MSB < TAG_LSB) || (TAG_W < IDX_W) || (TAG_MSB >= CHANNEL_WIDTH_OUT) ||
      (TAG_LSB < CHANNEL_WIDTH_IN)) begin : g_bad_tag
    $error("rr_tagged_combiner: illegal tag field placement/width");
  end

  logic [IDX_W-1:0]             r_ptr;
  logic                         r_locked;
  logic [IDX_W-1:0]             r_lock_ch;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic [CHANNEL_WIDTH_OUT-1:0] r_out_data;

  logic                         w_load;
  logic                         w_xfer;
  logic                         w_gnt_valid;
  logic [IDX_W-1:0]             w_gnt;
  logic [NUM_CHANNELS-1:0]      w_ready;
  logic [CHANNEL_WIDTH_IN-1:0]  w_payload;
  logic                         w_last_in;
  logic [CHANNEL_WIDTH_OUT-1:0] w_word;
  int unsigned                  w_dist;
  int unsigned                  w_best;

  assign w_load = !r_out_valid || bus.out_ready;

  // Each requester gets a priority distance: its index for fixed priority, or its
  // position in the rotated order ptr+1, ptr+2, ... for round-robin; smallest wins.
  always_comb begin
    w_gnt       = '0;
    w_gnt_valid = 1'b0;
    w_dist      = '0;
    w_best      = NUM_CHANNELS;
    if (r_locked) begin
      w_gnt       = r_lock_ch;
      w_gnt_valid = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        w_dist = (ARB_MODE != 0) ? ((i + NUM_CHANNELS - 32'(r_ptr) - 1) % NUM_CHANNELS) : i;
        if (bus.in_valid[i] && (w_dist < w_best)) begin
          w_best      = w_dist;
          w_gnt       = IDX_W'(i);
          w_gnt_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ready   = '0;
    w_payload = '0;
    w_last_in = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (w_gnt_valid && w_load && (w_gnt == IDX_W'(i)) && bus.in_valid[i]) begin
        w_ready[i] = 1'b1;
        w_payload  = bus.in_data[i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN];
        w_last_in  = bus.in_last[i];
      end
    end
  end

  assign w_xfer = |w_ready;

  always_comb begin
    w_word                          = '0;
    w_word[CHANNEL_WIDTH_IN-1:0]    = w_payload;
    w_word[TAG_MSB:TAG_LSB]         = TAG_W'(w_gnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_ptr       <= IDX_W'(NUM_CHANNELS - 1);
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_word;
          r_out_last <= w_last_in;
        end
      end
      if (w_xfer) begin
        r_ptr <= w_gnt;
        if (LOCK_PACKETS != 0) begin
          r_locked  <= !w_last_in;
          r_lock_ch <= w_gnt;
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;
endmodule

// File: doc/rr_tagged_combiner.md
Name: rr_tagged_combiner

Overview:
- Merges NUM_CHANNELS valid/ready input streams into one registered, tagged output stream.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Optional packet locking holds the grant on one channel until its last beat, so multi-beat messages (e.g. per-round defect lists from several FPGA links) never interleave.
- Sits between per-link channel logic and the single upstream/host link.

Parameters:
NUM_CHANNELS, 4, number of input channels (>=1)
CHANNEL_WIDTH_IN, 32, payload width per input channel
CHANNEL_WIDTH_OUT, 64, output word width
TAG_MSB, 55, MSB of channel-index tag field in out_data
TAG_LSB, 48, LSB of tag field; must be >= CHANNEL_WIDTH_IN
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
LOCK_PACKETS, 1, 1 = hold grant until beat with in_last accepted; 0 = re-arbitrate every beat

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_data  input  CHANNEL_WIDTH_IN*NUM_CHANNELS  channel i payload at [i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN]
in_valid  input  NUM_CHANNELS  per-channel valid
in_last  input  NUM_CHANNELS  per-channel last-beat-of-packet flag, qualified by in_valid
in_ready  output  NUM_CHANNELS  per-channel ready; at most one bit high (one-hot or zero)
out_data  output  CHANNEL_WIDTH_OUT  registered: payload [CHANNEL_WIDTH_IN-1:0], tag [TAG_MSB:TAG_LSB], all other bits 0
out_last  output  1  registered copy of the accepted beat's in_last
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_last=0.
  - RR pointer = NUM_CHANNELS-1, so channel 0 is first in RR order.
  - Lock cleared.
  - in_ready is combinational and is 0 while out_valid=0 and no in_valid is asserted.
- Output register load enable: load = !out_valid || out_ready. This gives full throughput (one beat per cycle) under continuous out_ready.
- Grant (combinational):
  - Locked: grant = locked channel.
  - Unlocked, ARB_MODE=0: lowest index with in_valid=1.
  - Unlocked, ARB_MODE=1: first index with in_valid=1 searching ptr+1, ptr+2, ... wrapping modulo NUM_CHANNELS.
- in_ready[g] = load && in_valid[g] for grant g; all other bits 0. No grant means all 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data = {zeros, tag=g zero-extended, payload}; out_last = in_last[g]; out_valid=1.
  - RR pointer := g (updated only on transfer).
- Output hold: if load=1 and there is no transfer, out_valid := 0. If load=0, all output registers hold. out_data must be stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Locking (LOCK_PACKETS=1):
  - A transfer with in_last=0 sets lock to g.
  - A transfer with in_last=1 clears lock.
  - While locked, other channels get no grant even if the locked channel drops in_valid (bubble cycles are permitted, no interleave).
  - LOCK_PACKETS=0: in_last is passed to out_last only; lock is never set.
- Simultaneous events: a channel asserting valid in the same cycle the lock clears competes only from the following cycle. Arbitration always uses the current registered pointer and lock.
- Width rules:
  - Tag width TAG_MSB-TAG_LSB+1 >= max(1, clog2(NUM_CHANNELS)).
  - TAG_MSB < CHANNEL_WIDTH_OUT.
  - Index width = max(1, clog2(NUM_CHANNELS)).
  - NUM_CHANNELS=1 is legal and degenerates to a registered pass-through with tag 0.
- Reset mid-packet: the lock and any held output beat are discarded. Upstream must restart the packet.

Test Plan:
- Reset; hold in_valid=4'b0000 -> out_valid=0, in_ready=0, out_data=0. Then ch2 valid with data 0xDEADBEEF, last=1 -> next cycle out_valid=1, out_data=0x00020000_DEADBEEF.
- RR, all 4 channels valid, single-beat (last=1), out_ready=1 constant -> tags 0,1,2,3,0,... on consecutive cycles, one beat per cycle. With ARB_MODE=0 -> tag 0 every cycle.
- Backpressure: out_ready=0 for 5 cycles with ch1 beat held -> out_data/out_valid stable and in_ready=0000. Release -> beat consumed exactly once, no loss or duplication (scoreboard).
- Lock: ch3 sends 3-beat packet (last on beat 3) while ch0 continuously valid, ch3 drops valid for 2 cycles mid-packet -> output tags 3,3,3 contiguous with 2 bubble cycles, then tag 0.
- LOCK_PACKETS=0, same stimulus -> ch3 and ch0 beats interleave per RR. out_last matches each beat's in_last.
- Reset asserted asynchronously mid-packet with out_valid=1 -> out_valid drops immediately. After release, channel 0 wins first among all-valid inputs.
